// File: rtl/load_store_unit_if.sv
// Data-memory bus between the load/store unit (master) and memory (slave).
interface load_store_unit_if;
  // Handshake: the master raises bus_req and holds bus_we/bus_adr/bus_wdata/bus_sel
  // stable until it samples bus_ack=1 on a rising edge. bus_rdata is valid in that
  // same cycle. The slave asserts bus_ack only while bus_req is high. The master
  // drops bus_req in the cycle after the ack.
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_adr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_sel;
  logic [31:0] bus_rdata;
  logic        bus_ack;

  modport master (
    output bus_req, bus_we, bus_adr, bus_wdata, bus_sel,
    input  bus_rdata, bus_ack
  );

  modport slave (
    input  bus_req, bus_we, bus_adr, bus_wdata, bus_sel,
    output bus_rdata, bus_ack
  );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store unit: one bus transaction per access, stalls the core meanwhile,
// returns an extended load value and flags misaligned/illegal/timed-out accesses.
module load_store_unit #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] address,
  input  logic [31:0] store_data,
  output logic [31:0] load_data,
  output logic        stall,
  output logic        done,
  output logic        fault,
  output logic [1:0]  state_dbg,
  load_store_unit_if.master bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUS = 2'd1, DONE = 2'd2, ERR = 2'd3} state_t;

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [2:0]    f3_q;
  logic [1:0]    lane_q;

  logic          req;
  logic          illegal;
  logic [3:0]    sel_d;
  logic [31:0]   wdata_d;
  logic [7:0]    byte_v;
  logic [15:0]   half_v;
  logic [31:0]   load_ext;

  assign state_dbg = state_q;
  assign req = mem_read | mem_write;

  // Decode the request: legality, byte enables and lane-replicated store data.
  always_comb begin
    illegal = (mem_read & mem_write)
            | (funct3[1:0] == 2'b11)
            | (funct3 == 3'b110)
            | (mem_write & funct3[2])
            | ((funct3[1:0] == 2'b01) & address[0])
            | ((funct3[1:0] == 2'b10) & (address[1:0] != 2'b00));
    sel_d   = 4'b1111;
    wdata_d = store_data;
    case (funct3[1:0])
      2'b00: begin
        sel_d   = 4'b0001 << address[1:0];
        wdata_d = {4{store_data[7:0]}};
      end
      2'b01: begin
        sel_d   = address[1] ? 4'b1100 : 4'b0011;
        wdata_d = {2{store_data[15:0]}};
      end
      default: begin
        sel_d   = 4'b1111;
        wdata_d = store_data;
      end
    endcase
  end

  // Pick the addressed byte/half out of the read word and extend it.
  always_comb begin
    byte_v = bus.bus_rdata[7:0];
    case (lane_q)
      2'd0: byte_v = bus.bus_rdata[7:0];
      2'd1: byte_v = bus.bus_rdata[15:8];
      2'd2: byte_v = bus.bus_rdata[23:16];
      default: byte_v = bus.bus_rdata[31:24];
    endcase
    half_v = lane_q[1] ? bus.bus_rdata[31:16] : bus.bus_rdata[15:0];
    case (f3_q)
      3'b000: load_ext = {{24{byte_v[7]}}, byte_v};
      3'b001: load_ext = {{16{half_v[15]}}, half_v};
      3'b100: load_ext = {24'd0, byte_v};
      3'b101: load_ext = {16'd0, half_v};
      default: load_ext = bus.bus_rdata;
    endcase
  end

  // Next-state and control outputs; stall is combinational so the core freezes in the request cycle.
  always_comb begin
    state_d     = state_q;
    stall       = 1'b0;
    done        = 1'b0;
    fault       = 1'b0;
    bus.bus_req = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (illegal) begin
            state_d = ERR;
          end else begin
            stall   = 1'b1;
            state_d = BUS;
          end
        end
      end
      BUS: begin
        stall       = 1'b1;
        bus.bus_req = 1'b1;
        if (bus.bus_ack) begin
          state_d = DONE;
        end else if ((TIMEOUT > 0) && (cnt_q == TO_LAST)) begin
          state_d = ERR;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        fault   = 1'b1;
        state_d = IDLE;
      end
    endcase
    if (rst) stall = 1'b0;
  end

  // State register, bus output latches, BUS-cycle counter and load result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      f3_q          <= 3'd0;
      lane_q        <= 2'd0;
      load_data     <= 32'd0;
      bus.bus_we    <= 1'b0;
      bus.bus_adr   <= 32'd0;
      bus.bus_wdata <= 32'd0;
      bus.bus_sel   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= (state_q == BUS) ? cnt_q + 1'b1 : '0;
      if (state_q == IDLE && state_d == BUS) begin
        f3_q          <= funct3;
        lane_q        <= address[1:0];
        bus.bus_we    <= mem_write;
        bus.bus_adr   <= {address[31:2], 2'b00};
        bus.bus_wdata <= wdata_d;
        bus.bus_sel   <= sel_d;
      end
      if (state_q == BUS && bus.bus_ack && !bus.bus_we) begin
        load_data <= load_ext;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: stores, sign/zero-extended loads, illegal
// accesses, bus timeout, ack on the last allowed cycle and reset mid-transaction.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  funct3;
  logic [31:0] address;
  logic [31:0] store_data;
  logic [31:0] load_data;
  logic        stall;
  logic        done;
  logic        fault;
  logic [1:0]  state_dbg;

  int n_vec = 0;
  int n_bad = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_load = 32'd0;

  load_store_unit_if bus_if ();

  load_store_unit #(.TIMEOUT(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .funct3     (funct3),
    .address    (address),
    .store_data (store_data),
    .load_data  (load_data),
    .stall      (stall),
    .done       (done),
    .fault      (fault),
    .state_dbg  (state_dbg),
    .bus        (bus_if.master)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #100000;
    n_bad++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    mem_read          = 1'b0;
    mem_write         = 1'b0;
    funct3            = 3'd0;
    address           = 32'd0;
    store_data        = 32'd0;
    bus_if.bus_ack    = 1'b0;
    bus_if.bus_rdata  = 32'd0;
  endtask

  // Legal access; memory acks in BUS cycle n (n >= 1).
  task automatic access(input string tag, input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rdata,
                        input int n, input logic [31:0] exp_wdata, input logic [3:0] exp_sel,
                        input logic [31:0] exp_load);
    int stalls;
    stalls = 0;
    mem_read = rd; mem_write = wr; funct3 = f3; address = addr; store_data = wd;
    if (rd) exp_q.push_back(exp_load);
    #1;
    if (stall) stalls++;
    check({tag, ":req_idle"}, 32'(bus_if.bus_req), 32'd0);
    for (int k = 1; k <= n; k++) begin
      step();
      if (k == n) begin
        bus_if.bus_ack   = 1'b1;
        bus_if.bus_rdata = rdata;
      end
      #1;
      if (stall) stalls++;
      check({tag, ":req_bus"}, 32'(bus_if.bus_req), 32'd1);
      if (k == 1) begin
        check({tag, ":adr"}, bus_if.bus_adr, {addr[31:2], 2'b00});
        check({tag, ":sel"}, 32'(bus_if.bus_sel), 32'(exp_sel));
        check({tag, ":we"}, 32'(bus_if.bus_we), 32'(wr));
        if (wr) check({tag, ":wdata"}, bus_if.bus_wdata, exp_wdata);
      end
    end
    step();
    bus_if.bus_ack   = 1'b0;
    bus_if.bus_rdata = 32'd0;
    #1;
    check({tag, ":done"}, 32'(done), 32'd1);
    check({tag, ":stall_done"}, 32'(stall), 32'd0);
    check({tag, ":req_done"}, 32'(bus_if.bus_req), 32'd0);
    check({tag, ":stall_cycles"}, 32'(stalls), 32'(n + 1));
    if (rd && exp_q.size() > 0) last_load = exp_q.pop_front();
    check({tag, ":load_data"}, load_data, last_load);
    step();
    mem_read = 1'b0; mem_write = 1'b0;
    #1;
    check({tag, ":done_pulse"}, 32'(done), 32'd0);
  endtask

  // Illegal access: fault next cycle, no bus cycle, load_data untouched.
  task automatic bad_access(input string tag, input logic rd, input logic wr,
                            input logic [2:0] f3, input logic [31:0] addr);
    mem_read = rd; mem_write = wr; funct3 = f3; address = addr; store_data = 32'h0BAD_F00D;
    #1;
    check({tag, ":stall"}, 32'(stall), 32'd0);
    check({tag, ":req0"}, 32'(bus_if.bus_req), 32'd0);
    step();
    #1;
    check({tag, ":fault"}, 32'(fault), 32'd1);
    check({tag, ":req1"}, 32'(bus_if.bus_req), 32'd0);
    check({tag, ":done"}, 32'(done), 32'd0);
    check({tag, ":load_data"}, load_data, last_load);
    step();
    mem_read = 1'b0; mem_write = 1'b0;
    #1;
    check({tag, ":fault_pulse"}, 32'(fault), 32'd0);
    check({tag, ":req2"}, 32'(bus_if.bus_req), 32'd0);
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    mem_read = 1'b1; funct3 = 3'b010;
    step();
    step();
    #1;
    check("rst:stall", 32'(stall), 32'd0);
    check("rst:req", 32'(bus_if.bus_req), 32'd0);
    check("rst:load_data", load_data, 32'd0);
    check("rst:done", 32'(done), 32'd0);
    check("rst:fault", 32'(fault), 32'd0);
    check("rst:sel", 32'(bus_if.bus_sel), 32'd0);
    check("rst:adr", bus_if.bus_adr, 32'd0);
    idle_inputs();
    rst = 1'b0;
    step();

    // Stores and loads with hand-computed lanes and extensions
    access("sw",  1'b0, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 3, 32'hDEADBEEF, 4'b1111, 32'h0);
    access("lb",  1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 32'h80123456, 2, 32'h0, 4'b1000, 32'hFFFFFF80);
    access("lbu", 1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 32'h80123456, 1, 32'h0, 4'b1000, 32'h00000080);
    access("sh",  1'b0, 1'b1, 3'b001, 32'h102, 32'h00001234, 32'h0, 2, 32'h12341234, 4'b1100, 32'h0);
    access("lh",  1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 32'h8001FFFF, 1, 32'h0, 4'b1100, 32'hFFFF8001);
    access("lhu", 1'b1, 1'b0, 3'b101, 32'h100, 32'h0, 32'h8001FFFF, 2, 32'h0, 4'b0011, 32'h0000FFFF);
    access("sb",  1'b0, 1'b1, 3'b000, 32'h101, 32'h000000AB, 32'h0, 1, 32'hABABABAB, 4'b0010, 32'h0);
    access("lw",  1'b1, 1'b0, 3'b010, 32'h104, 32'h0, 32'h12345678, 1, 32'h0, 4'b1111, 32'h12345678);

    // Illegal accesses
    bad_access("lw_mis",  1'b1, 1'b0, 3'b010, 32'h101);
    bad_access("st_f100", 1'b0, 1'b1, 3'b100, 32'h100);
    bad_access("ld_f111", 1'b1, 1'b0, 3'b111, 32'h100);
    bad_access("rd_wr",   1'b1, 1'b1, 3'b010, 32'h100);
    bad_access("lh_mis",  1'b1, 1'b0, 3'b001, 32'h101);
    bad_access("sw_mis",  1'b0, 1'b1, 3'b010, 32'h102);

    // Timeout: 8 BUS cycles with no ack, then fault
    mem_read = 1'b1; funct3 = 3'b010; address = 32'h108;
    #1;
    check("to:stall", 32'(stall), 32'd1);
    for (int k = 1; k <= 8; k++) begin
      step();
      #1;
      check("to:req_bus", 32'(bus_if.bus_req), 32'd1);
      check("to:no_fault", 32'(fault), 32'd0);
    end
    step();
    #1;
    check("to:fault", 32'(fault), 32'd1);
    check("to:req", 32'(bus_if.bus_req), 32'd0);
    check("to:done", 32'(done), 32'd0);
    check("to:load_data", load_data, last_load);
    step();
    mem_read = 1'b0;
    #1;
    check("to:fault_pulse", 32'(fault), 32'd0);

    // Ack on the last allowed BUS cycle completes normally
    access("lw_ack8", 1'b1, 1'b0, 3'b010, 32'h10C, 32'h0, 32'h55AA00FF, 8, 32'h0, 4'b1111, 32'h55AA00FF);

    // Reset in the second BUS cycle abandons the access
    mem_read = 1'b1; funct3 = 3'b010; address = 32'h110;
    step();
    step();
    #1;
    check("mr:req_bus2", 32'(bus_if.bus_req), 32'd1);
    rst = 1'b1;
    #1;
    check("mr:stall_rst", 32'(stall), 32'd0);
    step();
    #1;
    check("mr:req", 32'(bus_if.bus_req), 32'd0);
    check("mr:adr", bus_if.bus_adr, 32'd0);
    check("mr:sel", 32'(bus_if.bus_sel), 32'd0);
    check("mr:we", 32'(bus_if.bus_we), 32'd0);
    check("mr:wdata", bus_if.bus_wdata, 32'd0);
    check("mr:load_data", load_data, 32'd0);
    check("mr:done", 32'(done), 32'd0);
    check("mr:fault", 32'(fault), 32'd0);
    last_load = 32'd0;
    rst = 1'b0;
    mem_read = 1'b0;
    step();
    #1;
    check("mr:done_after", 32'(done), 32'd0);
    check("mr:fault_after", 32'(fault), 32'd0);
    access("lw_post", 1'b1, 1'b0, 3'b010, 32'h200, 32'h0, 32'hCAFEF00D, 2, 32'h0, 4'b1111, 32'hCAFEF00D);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
